// File: rtl/mux_sel_rr_arbiter_if.sv
// Bundle between four requesting sources and the round-robin arbiter that
// steers a 4:1 mux.
//   req   : request vector, bit i is source i
//   gnt   : one-hot grant, zero when idle
//   s1/s0 : mux select, {s1,s0} is the granted index
//   valid : mux output is meaningful
//   done  : one-cycle pulse after a grant ends
// The slave modport is the arbiter's view. The master modport is the
// requester's view.
interface mux_sel_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       valid;
  logic       done;

  modport master (output req, input gnt, s1, s0, valid, done);
  modport slave  (input req, output gnt, s1, s0, valid, done);
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter that drives the select lines of a 4:1 mux.
// A grant is held until one of two things happens:
//   - the owner drops its request, or
//   - BURST_LEN cycles have elapsed.
// When a grant ends, the next winner is granted on the same edge, so there
// is no bubble.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport carrying req / gnt / s1 / s0 / valid / done
module mux_sel_rr_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_sel_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

  state_e           state_q, state_d;
  logic [1:0]       cur_q, cur_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             grant_end;
  logic [1:0]       win_idle, win_end;

  // The search starts at lst+1 and ends at lst itself.
  // Iterating from the lowest priority upward lets the highest-priority
  // hit overwrite the earlier ones.
  function automatic logic [1:0] arb(input logic [1:0] lst, input logic [3:0] r);
    logic [1:0] idx;
    arb = lst;
    for (int k = 4; k >= 1; k--) begin
      idx = lst + 2'(k);
      if (r[idx]) arb = idx;
    end
  endfunction

  assign win_idle  = arb(last_q, bus.req);
  assign win_end   = arb(cur_q, bus.req);
  assign grant_end = !bus.req[cur_q] || (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          state_d = GRANT;
          cur_d   = win_idle;
          gnt_d   = 4'b0001 << win_idle;
          sel_d   = win_idle;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!grant_end) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          last_d = cur_q;
          done_d = 1'b1;
          // The owner may re-raise in the same cycle its grant ends.
          // The rotation from cur still applies in that case.
          if (bus.req != 4'b0000) begin
            cur_d   = win_end;
            gnt_d   = 4'b0001 << win_end;
            sel_d   = win_end;
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            // The select lines keep the last index so the mux output
            // stays stable while idle.
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt   = gnt_q;
  assign bus.s1    = sel_q[1];
  assign bus.s0    = sel_q[0];
  assign bus.valid = valid_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed bench for mux_sel_rr_arbiter.
// A cycle-level model tracks the expected grant owner, the cycles held and
// the rotation pointer. A compare process checks the BURST_LEN=4 instance
// against that model on every falling edge. Hand-computed literal checks pin
// the test-plan scenarios. A BURST_LEN=1 instance is checked with literals.
module tb_mux_sel_rr_arbiter;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mux_sel_rr_arbiter_if bus0();
  mux_sel_rr_arbiter_if bus1();

  mux_sel_rr_arbiter #(.BURST_LEN(BL), .CNT_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  mux_sel_rr_arbiter #(.BURST_LEN(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic [3:0] r);
    bus0.req = r;
    bus1.req = r;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: who owns the mux, and for how many cycles.
  bit       m_act, m_fin, m_done;
  int       m_owner, m_last, m_held, m_sel;

  function automatic int pick(input int lst, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(lst + k) % 4]) return (lst + k) % 4;
    return lst;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_done = 0; m_owner = 0; m_last = 3; m_held = 0; m_sel = 0;
    end else begin
      m_done = 0;
      m_fin  = 0;
      if (m_act) begin
        if (!bus0.req[m_owner] || m_held == BL) begin
          m_fin = 1; m_done = 1; m_last = m_owner;
        end else m_held++;
      end
      if (!m_act || m_fin) begin
        if (bus0.req != 4'b0000) begin
          m_owner = pick(m_last, bus0.req);
          m_act = 1; m_held = 1; m_sel = m_owner;
        end else m_act = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_gnt",   bus0.gnt, m_act ? (4'b0001 << m_owner) : 4'b0000);
    chk("model_sel",   {2'b00, bus0.s1, bus0.s0}, 4'(m_sel));
    chk("model_valid", {3'b000, bus0.valid}, {3'b000, m_act});
    chk("model_done",  {3'b000, bus0.done}, {3'b000, m_done});
  end

  logic [3:0] tail [12] = '{4'b1010, 4'b1010, 4'b1010, 4'b0110, 4'b0100, 4'b0000,
                            4'b1111, 4'b1110, 4'b0001, 4'b1001, 4'b1000, 4'b0000};

  initial begin
    // 1. reset values, then first grant after release
    set_req(4'b1111);
    step(3);
    chk("rst_gnt", bus0.gnt, 4'b0000);
    chk("rst_sel", {2'b00, bus0.s1, bus0.s0}, 4'b0000);
    chk("rst_valid_done", {2'b00, bus0.valid, bus0.done}, 4'b0000);
    rst_n = 1'b1;
    step(1);
    chk("first_gnt", bus0.gnt, 4'b0001);
    chk("first_sel", {2'b00, bus0.s1, bus0.s0}, 4'b0000);
    chk("b1_first_gnt", bus1.gnt, 4'b0001);
    // 3. full rotation with req=1111
    step(3);
    chk("rot_hold0", bus0.gnt, 4'b0001);
    chk("rot_hold0_done", {3'b000, bus0.done}, 4'b0000);
    chk("b1_rot_gnt", bus1.gnt, 4'b1000);
    chk("b1_rot_done", {3'b000, bus1.done}, 4'b0001);
    step(1);
    chk("rot_g1", bus0.gnt, 4'b0010);
    chk("rot_g1_sel", {2'b00, bus0.s1, bus0.s0}, 4'b0001);
    chk("rot_g1_done", {3'b000, bus0.done}, 4'b0001);
    chk("b1_wrap_gnt", bus1.gnt, 4'b0001);
    step(4);
    chk("rot_g2", bus0.gnt, 4'b0100);
    step(4);
    chk("rot_g3_sel", {2'b00, bus0.s1, bus0.s0}, 4'b0011);
    step(4);
    chk("rot_g0", bus0.gnt, 4'b0001);
    chk("rot_g0_done", {3'b000, bus0.done}, 4'b0001);
    set_req(4'b0000);
    step(1);
    chk("idle_gnt", bus0.gnt, 4'b0000);
    chk("idle_valid_done", {2'b00, bus0.valid, bus0.done}, 4'b0001);
    step(1);
    // 2. single burst on source 2
    set_req(4'b0100);
    step(1);
    chk("burst_gnt", bus0.gnt, 4'b0100);
    chk("burst_sel", {2'b00, bus0.s1, bus0.s0}, 4'b0010);
    step(3);
    chk("burst_last_done", {3'b000, bus0.done}, 4'b0000);
    step(1);
    chk("burst_regrant", bus0.gnt, 4'b0100);
    chk("burst_regrant_vd", {2'b00, bus0.valid, bus0.done}, 4'b0011);
    set_req(4'b0000);
    step(1);
    chk("burst_idle_sel", {1'b0, bus0.valid, bus0.s1, bus0.s0}, 4'b0010);
    // 4. early release: last=2, so source 0 wins 0011
    set_req(4'b0011);
    step(1);
    chk("early_g0", bus0.gnt, 4'b0001);
    step(1);
    set_req(4'b0010);
    step(1);
    chk("early_g1", bus0.gnt, 4'b0010);
    chk("early_sel_done", {1'b0, bus0.done, bus0.s1, bus0.s0}, 4'b0101);
    step(3);
    chk("early_cnt_restart", {3'b000, bus0.done}, 4'b0000);
    step(1);
    chk("early_expire", {3'b000, bus0.done}, 4'b0001);
    // 5. reach last=3, then 1001 picks source 0
    set_req(4'b1000);
    step(1);
    set_req(4'b0000);
    step(2);
    set_req(4'b1001);
    step(1);
    chk("wrap_gnt", bus0.gnt, 4'b0001);
    set_req(4'b0000);
    step(1);
    chk("wrap_idle_gnt", bus0.gnt, 4'b0000);
    chk("wrap_idle_sel", {1'b0, bus0.valid, bus0.s1, bus0.s0}, 4'b0000);
    // 6. reset in cycle 2 of a grant to source 2
    set_req(4'b0100);
    step(2);
    chk("pre_rst_gnt", bus0.gnt, 4'b0100);
    set_req(4'b0101);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", bus0.gnt, 4'b0000);
    chk("async_rst_rest", {bus0.valid, bus0.done, bus0.s1, bus0.s0}, 4'b0000);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_gnt", bus0.gnt, 4'b0001);
    chk("post_rst_done", {3'b000, bus0.done}, 4'b0000);
    // directed tail, checked by the model only
    foreach (tail[i]) begin
      set_req(tail[i]);
      step(3);
    end
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux_sel_rr_arbiter.md
# mux_sel_rr_arbiter

Round-robin arbiter that drives the select lines of a 4:1 multiplexer stage. Four sources raise requests; the block grants one at a time, holds the grant for a bounded burst, and presents the winner's index on `s1`/`s0` so the downstream 4:1 mux routes that source's data to `y`. A registered `valid` qualifies the mux output, and a one-cycle `done` pulse marks the end of each grant.

## Interface

Parameters:
- `BURST_LEN`, default 4: maximum consecutive cycles a single grant is held. Legal range is 1..8.
- `CNT_W`, default 3: width of the burst counter. Must satisfy 2^CNT_W >= BURST_LEN.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  4: request vector; `req[i]` is source i (d0..d3).
- `gnt`  out  4: one-hot grant, registered; all zeros when idle.
- `s1`  out  1: select MSB, registered; `{s1,s0}` is the granted index.
- `s0`  out  1: select LSB, registered.
- `valid`  out  1: high while a grant is active; the mux output is meaningful only when `valid` is high.
- `done`  out  1: one-cycle pulse in the cycle after a grant ends.

## Operation

- **State machine.** Two states: IDLE and GRANT. Internal registers:
  - `cur[1:0]`: index of the current grant.
  - `last[1:0]`: index of the last completed grant.
  - `cnt[CNT_W-1:0]`: burst counter.
- **Arbitration function.** Search order starts at `last+1` and wraps modulo 4. `last` itself is checked last, so a lone requester can be re-granted.
- **IDLE:**
  - If `req != 0`, pick the winner with the arbitration function. Set `cur` = winner, `gnt` = one-hot(winner), `{s1,s0}` = winner, `valid` = 1, `cnt` = 0, and go to GRANT.
  - Otherwise stay in IDLE with `gnt` = 0 and `valid` = 0.
- **GRANT, grant-end condition.** The grant ends when `req[cur]` == 0 (early release) or `cnt` == BURST_LEN-1 (burst expiry).
- **GRANT, grant not ending.** `cnt` increments; all outputs hold.
- **GRANT, grant ending:**
  - `last` <= `cur` and `done` <= 1.
  - The arbitration function is evaluated with `last` = `cur`.
  - If any request is present, the new winner is granted on the same edge: no bubble, `valid` stays 1, `cnt` = 0, state stays GRANT.
  - If no request is present, go to IDLE with `gnt` = 0 and `valid` = 0.
- **Select lines.** `{s1,s0}` change only when a new grant is issued. While idle they hold the last granted index, so the mux output stays stable.
- **Widths.** `cnt` never exceeds BURST_LEN-1. When BURST_LEN = 1, every grant lasts exactly one cycle and rotation occurs every cycle.
- **Simultaneous events.** If the grant ends and the requester re-raises in the same cycle, treat it as a normal end of grant: rotation applies, and the requester is re-granted only if no other request is present.

## Timing

- **Reset values (asynchronous, immediate on `rst_n` low):** state = IDLE, `gnt` = 4'b0000, `s1` = 0, `s0` = 0, `valid` = 0, `done` = 0, `cnt` = 0, `last` = 3. With `last` = 3, source 0 has first priority after reset.
- **Latency:** a request sampled at edge N produces `gnt`, select and `valid` after edge N. The result is visible during cycle N+1.
- **Burst length:** a continuously held request with no competition keeps its grant for exactly BURST_LEN cycles. It is then re-granted with a `done` pulse and `cnt` restarted.
- **`done` pulse:** high for exactly one cycle, coincident with the first cycle of the next grant or of IDLE.
- **Reset mid-grant:** all outputs drop to their reset values immediately, and no `done` is produced.
- **Deassertion of `rst_n`:** treated as synchronous to `clk` by the integrator. The first arbitration occurs on the first rising edge after release.

## Test plan

1. **Reset values.** Hold `rst_n`=0 with `req`=4'b1111 → `gnt`=0000, `{s1,s0}`=00, `valid`=0, `done`=0. Release reset → the next edge grants `gnt`=0001 and `{s1,s0}`=00.
2. **Single burst (BURST_LEN=4).** Set `req`=0100 continuously → `gnt`=0100 and `{s1,s0}`=10 for 4 cycles. Then `done`=1 for one cycle with `gnt` still 0100 (re-granted) and `valid` never dropping.
3. **Full rotation.** Set `req`=1111 continuously → grant order 0,1,2,3,0 with 4 cycles each. `{s1,s0}` steps 00,01,10,11,00, and `done` pulses every 4 cycles.
4. **Early release.** `req`=0011 and source 0 is granted; drop `req[0]` after 2 cycles → the next edge gives `gnt`=0010, `{s1,s0}`=01, `done`=1, and `cnt` restarts.
5. **Wraparound priority and return to idle.**
   - With `last`=3, raise `req`=1001 → source 0 is granted before source 3.
   - Then drop all requests → `valid`=0, `gnt`=0000, and `{s1,s0}` hold 00.
6. **Reset mid-grant.** Pull `rst_n` low in cycle 2 of a grant to source 2 → outputs go to reset values with no clock edge needed. After release, source 0 has priority over source 2.
